// File: rtl/branch_pc_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the PC sequencer.
package branch_pc_sequencer_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned REG_RA  = 31;

    localparam logic [XLEN-1:0] ID_BEQ  = 32'd15;
    localparam logic [XLEN-1:0] ID_BNE  = 32'd16;
    localparam logic [XLEN-1:0] ID_BGT  = 32'd17;
    localparam logic [XLEN-1:0] ID_BGTE = 32'd18;
    localparam logic [XLEN-1:0] ID_BLT  = 32'd19;
    localparam logic [XLEN-1:0] ID_BLEQ = 32'd20;
    localparam logic [XLEN-1:0] ID_J    = 32'd21;
    localparam logic [XLEN-1:0] ID_JR   = 32'd22;
    localparam logic [XLEN-1:0] ID_JAL  = 32'd23;
    localparam logic [XLEN-1:0] ID_HALT = 32'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } seq_state_t;

    // Control-transfer IDs resolve in a single EXEC cycle.
    function automatic logic is_ctrl_id(input logic [XLEN-1:0] id);
        return (id >= ID_BEQ) && (id <= ID_JAL);
    endfunction

endpackage

// File: rtl/branch_pc_sequencer_resolve.sv
// Combinational branch/jump resolution: next PC, taken flag and link request.
module branch_pc_sequencer_resolve
    import branch_pc_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] id,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] const_val,
    input  logic            signed_cmp,
    output logic [XLEN-1:0] next_pc,
    output logic            taken,
    output logic            is_link
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_pc;
    logic            eq;
    logic            gt;

    // Compare operands and pick the target; non-control IDs fall through to pc+4.
    always_comb begin
        seq_pc  = pc + 32'd4;
        rel_pc  = seq_pc + const_val;
        eq      = (a == b);
        gt      = signed_cmp ? ($signed(a) > $signed(b)) : (a > b);
        next_pc = seq_pc;
        taken   = 1'b0;
        is_link = 1'b0;
        case (id)
            ID_BEQ:  taken = eq;
            ID_BNE:  taken = !eq;
            ID_BGT:  taken = gt;
            ID_BGTE: taken = gt || eq;
            ID_BLT:  taken = !(gt || eq);
            ID_BLEQ: taken = !gt;
            ID_J: begin
                taken   = 1'b1;
                next_pc = const_val;
            end
            ID_JR: begin
                taken   = 1'b1;
                next_pc = a;
            end
            ID_JAL: begin
                taken   = 1'b1;
                is_link = 1'b1;
                next_pc = const_val;
            end
            default: ;
        endcase
        if ((id >= ID_BEQ) && (id <= ID_BLEQ) && taken) begin
            next_pc = rel_pc;
        end
    end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH/DECODE/EXEC/UPDATE with branch resolution and jal link write.
module branch_pc_sequencer
    import branch_pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     HALT_ID    = 31,
    parameter int unsigned     LINK_REG   = REG_RA,
    parameter bit              SIGNED_CMP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             instr_valid,
    input  logic [XLEN-1:0]  instr_ID,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [XLEN-1:0]  const_val,
    input  logic             exec_done,
    output logic [XLEN-1:0]  pc,
    output logic             branch_taken,
    output logic             flush,
    output logic             link_we,
    output logic [REG_W-1:0] link_addr,
    output logic [XLEN-1:0]  link_data,
    output logic             halted
);

    seq_state_t       state, state_n;
    logic [XLEN-1:0]  pc_n;
    logic [XLEN-1:0]  id_q, id_n, a_q, a_n, b_q, b_n, c_q, c_n;
    logic [XLEN-1:0]  npc_q, npc_n;
    logic             tk_q, tk_n, lk_q, lk_n;
    logic [XLEN-1:0]  res_npc;
    logic             res_tk, res_lk;
    logic             imem_req_n, bt_n, link_we_n, halted_n;
    logic [XLEN-1:0]  imem_addr_n, link_data_n;
    logic [REG_W-1:0] link_addr_n;

    branch_pc_sequencer_resolve u_resolve (
        .id         (id_q),
        .pc         (pc),
        .a          (a_q),
        .b          (b_q),
        .const_val  (c_q),
        .signed_cmp (SIGNED_CMP),
        .next_pc    (res_npc),
        .taken      (res_tk),
        .is_link    (res_lk)
    );

    // Next-state, datapath capture and next values of the registered outputs.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        id_n    = id_q;
        a_n     = a_q;
        b_n     = b_q;
        c_n     = c_q;
        npc_n   = npc_q;
        tk_n    = tk_q;
        lk_n    = lk_q;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_n    = RESET_PC;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                if (instr_valid) begin
                    id_n    = instr_ID;
                    a_n     = a;
                    b_n     = b;
                    c_n     = const_val;
                    state_n = (instr_ID == 32'(HALT_ID)) ? S_HALT : S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_ctrl_id(id_q) || exec_done) begin
                    npc_n   = res_npc;
                    tk_n    = res_tk;
                    lk_n    = res_lk;
                    state_n = S_UPDATE;
                end
            end
            S_UPDATE: begin
                pc_n    = npc_q;
                state_n = S_FETCH;
            end
            default: state_n = S_IDLE;
        endcase

        imem_req_n  = (state_n == S_FETCH);
        imem_addr_n = imem_req_n ? pc_n : '0;
        bt_n        = (state_n == S_UPDATE) && tk_n;
        link_we_n   = (state_n == S_UPDATE) && lk_n;
        link_addr_n = link_we_n ? REG_W'(LINK_REG) : '0;
        link_data_n = link_we_n ? (pc + 32'd4) : '0;
        halted_n    = (state_n == S_HALT);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            npc_q        <= '0;
            tk_q         <= 1'b0;
            lk_q         <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= '0;
            branch_taken <= 1'b0;
            link_we      <= 1'b0;
            link_addr    <= '0;
            link_data    <= '0;
            halted       <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            id_q         <= id_n;
            a_q          <= a_n;
            b_q          <= b_n;
            c_q          <= c_n;
            npc_q        <= npc_n;
            tk_q         <= tk_n;
            lk_q         <= lk_n;
            imem_req     <= imem_req_n;
            imem_addr    <= imem_addr_n;
            branch_taken <= bt_n;
            link_we      <= link_we_n;
            link_addr    <= link_addr_n;
            link_data    <= link_data_n;
            halted       <= halted_n;
        end
    end

    // Flush accompanies every taken transfer.
    assign flush = branch_taken;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: unsigned-compare (index 0) and signed-compare (index 1) instances.
module tb_branch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_ready = 1'b0;
    logic        instr_valid = 1'b0;
    logic        exec_done = 1'b0;
    logic [31:0] instr_ID = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] cval = '0;

    logic        imem_req [2];
    logic [31:0] imem_addr [2];
    logic [31:0] pc [2];
    logic        branch_taken [2];
    logic        flush [2];
    logic        link_we [2];
    logic [4:0]  link_addr [2];
    logic [31:0] link_data [2];
    logic        halted [2];

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    branch_pc_sequencer #(.RESET_PC(32'h0), .HALT_ID(31), .LINK_REG(31), .SIGNED_CMP(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req[0]), .imem_addr(imem_addr[0]), .imem_ready(imem_ready),
        .instr_valid(instr_valid), .instr_ID(instr_ID), .a(a), .b(b), .const_val(cval),
        .exec_done(exec_done), .pc(pc[0]), .branch_taken(branch_taken[0]), .flush(flush[0]),
        .link_we(link_we[0]), .link_addr(link_addr[0]), .link_data(link_data[0]), .halted(halted[0])
    );

    branch_pc_sequencer #(.RESET_PC(32'h0), .HALT_ID(31), .LINK_REG(31), .SIGNED_CMP(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req[1]), .imem_addr(imem_addr[1]), .imem_ready(imem_ready),
        .instr_valid(instr_valid), .instr_ID(instr_ID), .a(a), .b(b), .const_val(cval),
        .exec_done(exec_done), .pc(pc[1]), .branch_taken(branch_taken[1]), .flush(flush[1]),
        .link_we(link_we[1]), .link_addr(link_addr[1]), .link_data(link_data[1]), .halted(halted[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural next-PC rule: compare as mathematical integers, then wrap to 32 bits.
    function automatic logic [33:0] model_next(input logic [31:0] id, input logic [31:0] p,
                                               input logic [31:0] ra, input logic [31:0] rb,
                                               input logic [31:0] rc, input bit sgn);
        longint x, y;
        bit tk, lk;
        logic [31:0] tgt;
        x  = sgn ? longint'($signed(ra)) : longint'({32'h0, ra});
        y  = sgn ? longint'($signed(rb)) : longint'({32'h0, rb});
        tk = 1'b0;
        lk = 1'b0;
        tgt = p + 32'd4 + rc;
        if (id == 15) tk = (x == y);
        if (id == 16) tk = (x != y);
        if (id == 17) tk = (x > y);
        if (id == 18) tk = (x >= y);
        if (id == 19) tk = (x < y);
        if (id == 20) tk = (x <= y);
        if (id == 21 || id == 23) begin tk = 1'b1; tgt = rc; end
        if (id == 22) begin tk = 1'b1; tgt = ra; end
        if (id == 23) lk = 1'b1;
        return {lk, tk, tk ? tgt : (p + 32'd4)};
    endfunction

    // Reference model: phase 0 idle, 1 fetch, 2 decode, 3 exec, 4 update, 5 halt.
    int          m_ph [2];
    logic [31:0] m_pc [2], m_id [2], m_a [2], m_b [2], m_c [2], m_npc [2];
    bit          m_tk [2], m_lk [2];

    always @(posedge clk or posedge rst) begin
        logic [33:0] r;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_ph[k] <= 0; m_pc[k] <= 32'h0; m_tk[k] <= 1'b0; m_lk[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (m_ph[k])
                    0, 5: if (start) begin m_pc[k] <= 32'h0; m_ph[k] <= 1; end
                    1: if (imem_ready) m_ph[k] <= 2;
                    2: if (instr_valid) begin
                        m_id[k] <= instr_ID; m_a[k] <= a; m_b[k] <= b; m_c[k] <= cval;
                        m_ph[k] <= (instr_ID == 32'd31) ? 5 : 3;
                    end
                    3: if ((m_id[k] >= 15 && m_id[k] <= 23) || exec_done) begin
                        r = model_next(m_id[k], m_pc[k], m_a[k], m_b[k], m_c[k], k == 1);
                        m_lk[k] <= r[33]; m_tk[k] <= r[32]; m_npc[k] <= r[31:0];
                        m_ph[k] <= 4;
                    end
                    4: begin m_pc[k] <= m_npc[k]; m_ph[k] <= 1; end
                    default: m_ph[k] <= 0;
                endcase
            end
        end
    end

    // Per-cycle compare of every output of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                bit upd, lwe;
                upd = (m_ph[k] == 4);
                lwe = upd && m_lk[k];
                chk($sformatf("dut%0d pc", k), pc[k], m_pc[k]);
                chk($sformatf("dut%0d imem_req", k), 32'(imem_req[k]), 32'(m_ph[k] == 1));
                chk($sformatf("dut%0d imem_addr", k), imem_addr[k], (m_ph[k] == 1) ? m_pc[k] : 32'h0);
                chk($sformatf("dut%0d branch_taken", k), 32'(branch_taken[k]), 32'(upd && m_tk[k]));
                chk($sformatf("dut%0d flush", k), 32'(flush[k]), 32'(upd && m_tk[k]));
                chk($sformatf("dut%0d link_we", k), 32'(link_we[k]), 32'(lwe));
                chk($sformatf("dut%0d link_addr", k), 32'(link_addr[k]), lwe ? 32'd31 : 32'd0);
                chk($sformatf("dut%0d link_data", k), link_data[k], lwe ? m_pc[k] + 32'd4 : 32'h0);
                chk($sformatf("dut%0d halted", k), 32'(halted[k]), 32'(m_ph[k] == 5));
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one instruction from FETCH with all handshakes ready; ends at the next FETCH.
    task automatic run_instr(input logic [31:0] id, input logic [31:0] ia, input logic [31:0] ib,
                             input logic [31:0] ic, output int nfl, output int nlk,
                             output logic [31:0] ld, output logic [31:0] la);
        imem_ready = 1'b1; instr_valid = 1'b1; exec_done = 1'b1;
        instr_ID = id; a = ia; b = ib; cval = ic;
        nfl = 0; nlk = 0; ld = '0; la = '0;
        repeat (4) begin
            @(negedge clk);
            if (flush[1]) nfl++;
            if (link_we[1]) begin nlk++; ld = link_data[1]; la = 32'(link_addr[1]); end
        end
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nfl, nlk;
        logic [31:0] ld, la;
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("reset pc", pc[1], 32'h0);
        chk("reset imem_req", 32'(imem_req[1]), 32'h0);
        chk("reset halted", 32'(halted[1]), 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        do_start();
        chk("start imem_req", 32'(imem_req[1]), 32'h1);
        chk("start imem_addr", imem_addr[1], 32'h0);
        run_instr(32'd0, 32'h0, 32'h0, 32'h0, nfl, nlk, ld, la);
        chk("nop pc", pc[1], 32'h4);
        chk("nop no flush", 32'(nfl), 32'h0);

        #3 rst = 1'b1;
        #1;
        chk("async rst pc", pc[1], 32'h0);
        chk("async rst imem_req", 32'(imem_req[1]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_start();

        run_instr(32'd21, 32'h0, 32'h0, 32'h100, nfl, nlk, ld, la);
        chk("j pc", pc[1], 32'h100);
        run_instr(32'd15, 32'd7, 32'd7, 32'h20, nfl, nlk, ld, la);
        chk("beq taken pc", pc[1], 32'h124);
        chk("beq taken flush cycles", 32'(nfl), 32'h1);
        run_instr(32'd21, 32'h0, 32'h0, 32'h100, nfl, nlk, ld, la);
        run_instr(32'd15, 32'd7, 32'd8, 32'h20, nfl, nlk, ld, la);
        chk("beq not taken pc", pc[1], 32'h104);
        chk("beq not taken flush", 32'(nfl), 32'h0);

        run_instr(32'd17, 32'hFFFF_FFFF, 32'h1, 32'h10, nfl, nlk, ld, la);
        chk("bgt signed pc", pc[1], 32'h108);
        chk("bgt unsigned pc", pc[0], 32'h118);

        run_instr(32'd21, 32'h0, 32'h0, 32'h40, nfl, nlk, ld, la);
        run_instr(32'd23, 32'h0, 32'h0, 32'h200, nfl, nlk, ld, la);
        chk("jal pc", pc[1], 32'h200);
        chk("jal link_we cycles", 32'(nlk), 32'h1);
        chk("jal link_data", ld, 32'h44);
        chk("jal link_addr", la, 32'd31);
        run_instr(32'd22, 32'h44, 32'h0, 32'h0, nfl, nlk, ld, la);
        chk("jr pc", pc[1], 32'h44);

        run_instr(32'd21, 32'h0, 32'h0, 32'hFFFF_FFFC, nfl, nlk, ld, la);
        imem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall imem_req", 32'(imem_req[1]), 32'h1);
            chk("stall imem_addr", imem_addr[1], 32'hFFFF_FFFC);
        end
        run_instr(32'd5, 32'h0, 32'h0, 32'h0, nfl, nlk, ld, la);
        chk("wrap pc", pc[1], 32'h0);

        run_instr(32'd21, 32'h0, 32'h0, 32'h80, nfl, nlk, ld, la);
        instr_ID = 32'd31; imem_ready = 1'b1; instr_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("halt halted", 32'(halted[1]), 32'h1);
        repeat (10) begin
            instr_valid = 1'($urandom); exec_done = 1'($urandom); imem_ready = 1'($urandom);
            instr_ID = $urandom_range(0, 40);
            @(negedge clk);
            chk("halt frozen pc", pc[1], 32'h80);
            chk("halt stays", 32'(halted[1]), 32'h1);
        end
        do_start();
        chk("restart pc", pc[1], 32'h0);
        chk("restart imem_req", 32'(imem_req[1]), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom_range(0, 19) == 0);
            imem_ready  = ($urandom_range(0, 9) < 7);
            instr_valid = ($urandom_range(0, 9) < 7);
            exec_done   = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 19))
                0:       instr_ID = 32'd31;
                1, 2, 3: instr_ID = $urandom_range(0, 40);
                4:       instr_ID = $urandom;
                default: instr_ID = 32'd15 + $urandom_range(0, 8);
            endcase
            a = pick_op(); b = pick_op(); cval = $urandom;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
